// File: rtl/if_fetch.sv
// Instruction-fetch stage: one outstanding SRAM request at a time, buffering
// the returned word while ID is stalled, and redirecting after the delay slot.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [32:0] br_bus,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic [32:0] if_to_id_bus,
  output logic [31:0] if_inst,
  output logic        stallreq
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic        redir_v;
  logic [31:0] redir_pc;
  logic        hold_v;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;
  logic        discard;

  logic        br_e;
  logic [31:0] br_addr;
  logic        id_stop;
  logic        accept;
  logic [31:0] next_pc;
  logic        unused_bits;

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];
  assign id_stop = stall[1];

  assign inst_sram_req  = !rst && (state == S_REQ) && !stall[0] && !discard;
  assign inst_sram_addr = {fetch_pc[31:2], 2'b00};
  assign stallreq       = !rst && ((state == S_REQ) ||
                                   ((state == S_WAIT) && !inst_sram_data_ok));

  always_comb begin
    if_to_id_bus = '0;
    if_inst      = '0;
    if (!rst) begin
      if ((state == S_WAIT) && inst_sram_data_ok) begin
        if_to_id_bus = {1'b1, fetch_pc};
        if_inst      = inst_sram_rdata;
      end else if ((state == S_HOLD) && hold_v) begin
        if_to_id_bus = {1'b1, hold_pc};
        if_inst      = hold_inst;
      end
    end
  end

  // A redirect arriving in the same cycle as the delay slot is accepted wins
  assign accept  = if_to_id_bus[32] && !id_stop;
  assign next_pc = br_e ? br_addr : (redir_v ? redir_pc : fetch_pc + 32'd4);

  assign unused_bits = ^{stall[5:2], fetch_pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_REQ;
      fetch_pc  <= RESET_PC;
      redir_v   <= 1'b0;
      redir_pc  <= '0;
      hold_v    <= 1'b0;
      hold_pc   <= '0;
      hold_inst <= '0;
      // Remember a request the SRAM still owes us so its data is dropped later
      discard   <= ((state == S_WAIT) && !inst_sram_data_ok) ||
                   ((state == S_REQ) && inst_sram_addr_ok) ||
                   (discard && !inst_sram_data_ok);
    end else begin
      if (br_e) begin
        redir_v  <= 1'b1;
        redir_pc <= br_addr;
      end
      if (accept) begin
        fetch_pc <= next_pc;
        redir_v  <= 1'b0;
      end
      case (state)
        S_REQ: begin
          if (discard) begin
            if (inst_sram_data_ok) discard <= 1'b0;
          end else if (inst_sram_req && inst_sram_addr_ok) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (inst_sram_data_ok) begin
            if (id_stop) begin
              state     <= S_HOLD;
              hold_v    <= 1'b1;
              hold_pc   <= fetch_pc;
              hold_inst <= inst_sram_rdata;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!id_stop) begin
            state  <= S_REQ;
            hold_v <= 1'b0;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: cycle vectors for the fixed sequences, then an SRAM
// model plus a delivery scoreboard for branches, wrap and reset mid-request.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic        req;
  logic [31:0] addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic [32:0] bus;
  logic [31:0] inst;
  logic        sreq;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_bus(br_bus),
    .inst_sram_req(req), .inst_sram_addr(addr),
    .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok),
    .inst_sram_rdata(rdata), .if_to_id_bus(bus), .if_inst(inst),
    .stallreq(sreq)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  typedef struct {
    logic        r;
    logic [5:0]  st;
    logic        a;
    logic        d;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ce;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_sreq;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [5:0] st, input logic a,
                              input logic d, input logic [31:0] rd, input logic e_req,
                              input logic [31:0] e_addr, input logic e_ce,
                              input logic [31:0] e_pc, input logic [31:0] e_inst,
                              input logic e_sreq);
    vec_t v;
    v.r = r; v.st = st; v.a = a; v.d = d; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_ce = e_ce;
    v.e_pc = e_pc; v.e_inst = e_inst; v.e_sreq = e_sreq;
    return v;
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        q[$];
  logic [31:0] hist[$];
  logic [31:0] exp_addr = RESET_PC;
  logic        redir_pend = 1'b0;
  logic [31:0] redir_tgt = '0;
  logic        id_v = 1'b0;
  logic [31:0] id_pc = '0;
  logic [31:0] br_from[2] = '{32'hBFC0_0010, 32'hBFC0_0104};
  logic [31:0] br_to[2]   = '{32'hBFC0_0100, 32'hFFFF_FFFC};

  logic        pending = 1'b0;
  logic [31:0] pend_addr = '0;
  int          d_cnt = 0;
  int          a_cnt = 0;
  int          addr_lat = 0;
  int          data_lat = 1;
  logic        rand_lat = 1'b1;
  logic        last_acc;
  logic        s_req;
  logic [31:0] s_addr;

  // One cycle against the SRAM model; inputs change on the falling edge
  task automatic sb_tick(input logic r, input logic [5:0] st);
    logic        be;
    logic [31:0] ba;
    logic        acc;
    @(negedge clk);
    rst   = r;
    stall = st;
    be    = 1'b0;
    ba    = '0;
    if (!r && id_v) begin
      for (int k = 0; k < 2; k++) begin
        if (id_pc == br_from[k]) begin
          be = 1'b1;
          ba = br_to[k];
        end
      end
    end
    br_bus = {be, ba};
    #1;
    addr_ok = !pending && req && (a_cnt >= addr_lat);
    data_ok = pending && (d_cnt >= data_lat);
    rdata   = data_ok ? inst_of(pend_addr) : $urandom;
    #1;
    s_req    = req;
    s_addr   = addr;
    last_acc = req && addr_ok;
    if (r) begin
      chk("reset_outputs", 128'({req, bus, inst, sreq}), 128'(0));
      q.delete();
      exp_addr   = RESET_PC;
      redir_pend = 1'b0;
      id_v       = 1'b0;
    end else begin
      chk("stallreq", 128'(sreq), 128'(!bus[32]));
      if (req) begin
        chk("one_outstanding", 128'(pending), 128'(0));
        chk("req_addr", 128'(addr), 128'(exp_addr));
      end
      if (bus[32]) begin
        if (q.size() == 0) chk("ce_without_request", 128'(bus[32]), 128'(0));
        else chk("deliver", 128'({bus, inst}), 128'({1'b1, q[0].pc, q[0].ins}));
      end
      if (req && addr_ok) begin
        q.push_back('{pc: exp_addr, ins: inst_of(exp_addr)});
        hist.push_back(addr);
      end
      if (be) begin
        redir_pend = 1'b1;
        redir_tgt  = ba;
      end
      acc = bus[32] && !st[1];
      if (acc && q.size() > 0) begin
        $display("deliver pc=%h inst=%h", bus[31:0], inst);
        id_pc = q[0].pc;
        id_v  = 1'b1;
        void'(q.pop_front());
        exp_addr   = redir_pend ? redir_tgt : exp_addr + 32'd4;
        redir_pend = 1'b0;
      end
    end
    if (data_ok) pending = 1'b0;
    else if (pending) d_cnt++;
    if (addr_ok) begin
      pending   = 1'b1;
      pend_addr = addr;
      d_cnt     = 1;
      if (rand_lat) begin
        data_lat = $urandom_range(1, 3);
        addr_lat = $urandom_range(0, 2);
      end
    end
    if (req && !addr_ok) a_cnt++;
    else a_cnt = 0;
  endtask

  vec_t vt[18];

  initial begin
    logic [31:0] i0, i1, i2;
    logic        found;
    i0 = 32'h3C01_BFC0;
    i1 = 32'h2402_0005;
    i2 = 32'h8C22_0000;
    //         rst stall      aok  dok  rdata  req  addr          ce   pc            inst  sreq
    vt[0]  = mk(1, 6'b000000, 0, 0, 32'h0, 0, 32'hBFC0_0000, 0, 32'h0,         32'h0, 0);
    vt[1]  = mk(0, 6'b000000, 1, 0, 32'h0, 1, 32'hBFC0_0000, 0, 32'h0,         32'h0, 1);
    vt[2]  = mk(0, 6'b000000, 0, 1, i0,    0, 32'hBFC0_0000, 1, 32'hBFC0_0000, i0,    0);
    vt[3]  = mk(0, 6'b000000, 0, 0, 32'h0, 1, 32'hBFC0_0004, 0, 32'h0,         32'h0, 1);
    vt[4]  = mk(0, 6'b000000, 0, 0, 32'h0, 1, 32'hBFC0_0004, 0, 32'h0,         32'h0, 1);
    vt[5]  = mk(0, 6'b000000, 1, 0, 32'h0, 1, 32'hBFC0_0004, 0, 32'h0,         32'h0, 1);
    vt[6]  = mk(0, 6'b000000, 0, 0, 32'h0, 0, 32'hBFC0_0004, 0, 32'h0,         32'h0, 1);
    vt[7]  = mk(0, 6'b000000, 0, 0, 32'h0, 0, 32'hBFC0_0004, 0, 32'h0,         32'h0, 1);
    vt[8]  = mk(0, 6'b000010, 0, 1, i1,    0, 32'hBFC0_0004, 1, 32'hBFC0_0004, i1,    0);
    vt[9]  = mk(0, 6'b000010, 0, 0, 32'h0, 0, 32'hBFC0_0004, 1, 32'hBFC0_0004, i1,    0);
    vt[10] = mk(0, 6'b000010, 0, 0, 32'h0, 0, 32'hBFC0_0004, 1, 32'hBFC0_0004, i1,    0);
    vt[11] = mk(0, 6'b000010, 0, 0, 32'h0, 0, 32'hBFC0_0004, 1, 32'hBFC0_0004, i1,    0);
    vt[12] = mk(0, 6'b000000, 0, 0, 32'h0, 0, 32'hBFC0_0004, 1, 32'hBFC0_0004, i1,    0);
    vt[13] = mk(0, 6'b000000, 0, 0, 32'h0, 1, 32'hBFC0_0008, 0, 32'h0,         32'h0, 1);
    vt[14] = mk(0, 6'b000001, 0, 0, 32'h0, 0, 32'hBFC0_0008, 0, 32'h0,         32'h0, 1);
    vt[15] = mk(0, 6'b000000, 1, 0, 32'h0, 1, 32'hBFC0_0008, 0, 32'h0,         32'h0, 1);
    vt[16] = mk(0, 6'b000000, 0, 1, i2,    0, 32'hBFC0_0008, 1, 32'hBFC0_0008, i2,    0);
    vt[17] = mk(0, 6'b000000, 0, 0, 32'h0, 1, 32'hBFC0_000C, 0, 32'h0,         32'h0, 1);

    rst = 1'b1; stall = '0; br_bus = '0; addr_ok = 0; data_ok = 0; rdata = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rst = vt[i].r; stall = vt[i].st; addr_ok = vt[i].a; data_ok = vt[i].d; rdata = vt[i].rd;
      #1;
      $display("vec %0d req=%b addr=%h ce=%b pc=%h inst=%h stallreq=%b",
               i, req, addr, bus[32], bus[31:0], inst, sreq);
      chk($sformatf("vec%0d", i), 128'({req, addr, bus, inst, sreq}),
          128'({vt[i].e_req, vt[i].e_addr, vt[i].e_ce, vt[i].e_pc, vt[i].e_inst, vt[i].e_sreq}));
    end

    // Branch and wrap run with random SRAM latency and ID stalls
    repeat (2) sb_tick(1'b1, 6'b000000);
    for (int c = 0; c < 300; c++)
      sb_tick(1'b0, ($urandom_range(0, 3) == 0) ? 6'b000011 : 6'b000000);
    found = 1'b0;
    for (int i = 0; i + 2 < hist.size(); i++) begin
      if (!found && hist[i] == 32'hBFC0_0014) begin
        found = 1'b1;
        chk("branch_target", 128'(hist[i+1]), 128'(32'hBFC0_0100));
        chk("branch_target_plus4", 128'(hist[i+2]), 128'(32'hBFC0_0104));
      end
    end
    chk("branch_seq_found", 128'(found), 128'(1));
    found = 1'b0;
    for (int i = 0; i + 1 < hist.size(); i++) begin
      if (!found && hist[i] == 32'hFFFF_FFFC) begin
        found = 1'b1;
        chk("pc_wrap", 128'(hist[i+1]), 128'(32'h0000_0000));
      end
    end
    chk("wrap_seq_found", 128'(found), 128'(1));

    // Reset one cycle after a request is accepted; its data arrives later
    rand_lat = 1'b0;
    addr_lat = 0;
    data_lat = 4;
    repeat (2) sb_tick(1'b1, 6'b000000);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      sb_tick(1'b0, 6'b000000);
      found = last_acc;
    end
    chk("accept_before_reset", 128'(found), 128'(1));
    data_lat = 4;
    sb_tick(1'b1, 6'b000000);
    for (int c = 0; c < 3; c++) begin
      sb_tick(1'b0, 6'b000000);
      chk("orphan_req_low", 128'(s_req), 128'(0));
    end
    data_lat = 1;
    sb_tick(1'b0, 6'b000000);
    chk("post_orphan_req", 128'({s_req, s_addr}), 128'({1'b1, RESET_PC}));
    repeat (8) sb_tick(1'b0, 6'b000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
